// File: rtl/sb_interconnect.sv
// rtl/sb_interconnect.sv - system-bus interconnect: LSU port to N slaves
// One-hot decode, single-cycle slave request, ready/timeout wait, registered response, error capture.
module sb_interconnect #(
  parameter int                  N_SLAVES     = 9,
  parameter int                  SEL_LO       = 24,
  parameter logic [N_SLAVES-1:0] ALWAYS_READY = 9'b000000110,
  parameter int                  TIMEOUT      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     m_req_i,
  input  logic                     m_we_i,
  input  logic [3:0]               m_be_i,
  input  logic [31:0]              m_addr_i,
  input  logic [31:0]              m_wd_i,
  output logic [31:0]              m_rd_o,
  output logic                     m_ready_o,
  output logic                     m_err_o,
  output logic [N_SLAVES-1:0]      s_req_o,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wd_o,
  input  logic [32*N_SLAVES-1:0]   s_rd_i,
  input  logic [N_SLAVES-1:0]      s_ready_i,
  output logic                     busy_o,
  output logic [31:0]              err_addr_o,
  output logic [7:0]               err_cnt_o
);

  localparam int SEL_W = 32 - SEL_LO;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [N_SLAVES-1:0]   sel_oh_q, sel_oh_d;
  logic [31:0]           addr_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  cap, err_log;
  logic [N_SLAVES-1:0]   s_req_d;
  logic                  m_ready_d, m_err_d;
  logic [31:0]           m_rd_d, slave_rd;
  logic                  rdy_req, rdy_wait;

  // Decode is one-hot on the raw select field; an unmapped select decodes to all-zero.
  always_comb begin
    sel_oh_d = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      sel_oh_d[k] = (m_addr_i[31:SEL_LO] == SEL_W'(k));
    end
  end

  always_comb begin
    slave_rd = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_oh_q[k]) slave_rd = s_rd_i[32*k +: 32];
    end
  end

  assign rdy_req  = |((s_ready_i | ALWAYS_READY) & sel_oh_q);
  assign rdy_wait = |(s_ready_i & sel_oh_q);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cap       = 1'b0;
    err_log   = 1'b0;
    s_req_d   = '0;
    m_ready_d = 1'b0;
    m_err_d   = 1'b0;
    m_rd_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (m_req_i) begin
          cap = 1'b1;
          if (|sel_oh_d) begin
            state_d = REQ;
            s_req_d = sel_oh_d;
          end else begin
            state_d   = RESP;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            err_log   = 1'b1;
          end
        end
      end
      REQ: begin
        if (rdy_req) begin
          state_d   = RESP;
          m_ready_d = 1'b1;
          m_rd_d    = slave_rd;
        end else begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ready takes priority over an expiring timer in the same cycle.
        if (rdy_wait) begin
          state_d   = RESP;
          m_ready_d = 1'b1;
          m_rd_d    = slave_rd;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = RESP;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          err_log   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sel_oh_q   <= '0;
      addr_q     <= '0;
      timer_q    <= '0;
      s_req_o    <= '0;
      m_ready_o  <= 1'b0;
      m_err_o    <= 1'b0;
      m_rd_o     <= '0;
      busy_o     <= 1'b0;
      s_we_o     <= 1'b0;
      s_be_o     <= '0;
      s_addr_o   <= '0;
      s_wd_o     <= '0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      s_req_o   <= s_req_d;
      m_ready_o <= m_ready_d;
      m_err_o   <= m_err_d;
      m_rd_o    <= m_rd_d;
      busy_o    <= (state_d != IDLE);
      if (cap) begin
        addr_q   <= m_addr_i;
        sel_oh_q <= sel_oh_d;
        s_we_o   <= m_we_i;
        s_be_o   <= m_be_i;
        s_addr_o <= {{SEL_W{1'b0}}, m_addr_i[SEL_LO-1:0]};
        s_wd_o   <= m_wd_i;
      end
      if (err_log) begin
        err_addr_o <= cap ? m_addr_i : addr_q;
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: doc/sb_interconnect.md
# sb_interconnect

Parametrised system-bus interconnect between the LSU memory port and N peripheral/memory slaves. It decodes the top address field into a one-hot slave request and issues a single-cycle request to that slave. It waits for a per-slave ready, or treats the slave as always-ready by mask. It returns a registered read word, with a bus-error response for unmapped addresses or slaves that time out. It replaces the hard-wired 3-slave decode/mux in the top level and adds error capture.

## Interface
Parameters:
- N_SLAVES, 9, number of slave channels; channel k decodes address[31:SEL_LO] == k
- SEL_LO, 24, lowest bit of the slave-select field; select width = 32-SEL_LO
- ALWAYS_READY, 9'b000000110, bit k set: slave k is ready in its request cycle and s_ready_i[k] is ignored
- TIMEOUT, 16, WAIT cycles allowed before bus error (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  system clock (slow_clk domain)
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  1  master request, held until m_ready_o
- m_we_i  in  1  write enable
- m_be_i  in  4  byte enables
- m_addr_i  in  32  byte address
- m_wd_i  in  32  write data
- m_rd_o  out  32  read data, valid with m_ready_o
- m_ready_o  out  1  one-cycle response strobe
- m_err_o  out  1  bus error, valid with m_ready_o
- s_req_o  out  N_SLAVES  one-hot slave request
- s_we_o  out  1  write enable to slaves
- s_be_o  out  4  byte enables to slaves
- s_addr_o  out  32  local address: select field zeroed, low SEL_LO bits kept
- s_wd_o  out  32  write data to slaves
- s_rd_i  in  32*N_SLAVES  flattened read data, slave k at [32k+31:32k]
- s_ready_i  in  N_SLAVES  per-slave ready
- busy_o  out  1  state != IDLE
- err_addr_o  out  32  address of the most recent errored transaction
- err_cnt_o  out  8  saturating error counter

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, m_req_i=1:
  - Capture addr/we/be/wd and sel = m_addr_i[31:SEL_LO].
  - sel < N_SLAVES: go to REQ.
  - Otherwise: set err_q and go to RESP.
  - m_req_i=0: stay in IDLE.
- REQ, exactly one cycle:
  - s_req_o = 1<<sel_q. s_we/be/addr/wd_o are driven from the captured registers.
  - If ALWAYS_READY[sel_q] or s_ready_i[sel_q]: capture s_rd_i slice into rdata_q and go to RESP.
  - Otherwise: timer = 0 and go to WAIT.
- WAIT:
  - s_req_o = 0; the captured address and data stay driven.
  - s_ready_i[sel_q]=1: capture rdata and go to RESP. Ready wins over timeout in the same cycle.
  - Else if timer == TIMEOUT-1: set err_q and go to RESP.
  - Else timer+1.
- RESP, one cycle:
  - m_ready_o=1. m_rd_o = rdata_q, or 0 if err_q. m_err_o = err_q.
  - Always go to IDLE. m_req_i is ignored in RESP; the master drops it on seeing ready.
- Error capture: when entering RESP with an error, err_addr_o ← captured addr and err_cnt_o ← min(err_cnt_o+1, 255).
- Writes complete the same way; rdata_q is captured but is don't-care for writes.
- No other slave's request bit is ever asserted. s_req_o is all-zero outside REQ.

## Timing
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - m_ready_o, m_err_o, s_req_o, busy_o, err_cnt_o are 0.
  - m_rd_o, err_addr_o, s_addr_o, s_wd_o, s_be_o, s_we_o are 0.
- Reset mid-transaction: the transaction is abandoned immediately with no response.
- Latency, request accepted at edge of cycle 0:
  - REQ in cycle 1.
  - Always-ready or immediately-ready slave: m_ready_o in cycle 2.
  - Slave ready in WAIT cycle 1+d: m_ready_o in cycle 2+d.
  - Unmapped address: m_ready_o and m_err_o in cycle 1. No s_req_o.
  - Timeout: WAIT occupies cycles 2..TIMEOUT+1; error response in cycle TIMEOUT+2.
- Throughput: at most one transaction per 3 cycles. The next request is sampled in the IDLE cycle after RESP.
- All outputs are registered. There is no combinational path from m_* or s_ready_i to any output.

## Test plan
- Read of an always-ready slave: m_addr=0x0100_0004, slave 1 data 0xDEAD_BEEF.
  - s_req_o=9'h002 in cycle 1 only; s_addr_o=0x0000_0004.
  - m_ready_o in cycle 2 with m_rd_o=0xDEAD_BEEF and m_err_o=0.
- Write to slave 0 with ready 3 cycles after REQ: m_addr=0x0000_0010, be=4'b0011, wd=0x1234_5678.
  - s_req_o=9'h001 for one cycle; s_we_o=1; s_be_o=4'b0011.
  - m_ready_o in cycle 5 with m_err_o=0.
- Unmapped address 0x0A00_0000:
  - s_req_o stays 0.
  - m_ready_o and m_err_o in cycle 1 with m_rd_o=0.
  - err_addr_o=0x0A00_0000 and err_cnt_o=1.
- Timeout with slave 0 never ready, TIMEOUT=16:
  - Error response in cycle 18.
  - Repeat with ready asserted in cycle 17: normal response in cycle 18 with m_err_o=0.
- Reset in WAIT: drop rst_ni in cycle 3.
  - All outputs are 0 asynchronously; no m_ready_o is ever produced.
  - A new read after release completes normally.
- Error counter saturation and back-to-back traffic:
  - 260 unmapped accesses leave err_cnt_o=255.
  - Two consecutive reads held by the master complete in cycles 2 and 5.
